// File: rtl/q_pulse_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : q_pulse_meter                                                    |
// | Brief   : Counts synchronized pulses of a serialized charge train into a   |
// |           saturating Q word, published with a strobe at end of burst.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module q_pulse_meter #(
    parameter int BUS_WIDTH     = 10,
    parameter int Q_PER_PULSE   = 3,
    parameter int WTD_BUS_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 q_serialized,
    output logic [BUS_WIDTH-1:0] q_measured,
    output logic                 ready,
    output logic                 saturated,
    output logic                 busy
);

    localparam logic [BUS_WIDTH:0]       c_ACC_MAX  = {1'b0, {BUS_WIDTH{1'b1}}};
    localparam logic [BUS_WIDTH:0]       c_Q_STEP   = (BUS_WIDTH+1)'(Q_PER_PULSE);
    // Index of the last tolerated low sample; the next low one ends the burst.
    localparam logic [WTD_BUS_WIDTH-1:0] c_LOW_LAST = WTD_BUS_WIDTH'((2**WTD_BUS_WIDTH) - 2);

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_COUNT = 1'b1;

    logic [0:0]               r_state;
    logic                     r_sync1;
    logic                     r_s;
    logic                     r_s_d;
    logic [BUS_WIDTH-1:0]     r_acc;
    logic [WTD_BUS_WIDTH-1:0] r_low;
    logic                     r_sat;
    logic [BUS_WIDTH-1:0]     r_q;
    logic                     r_ready;
    logic                     r_saturated;
    logic                     r_busy;

    logic                     w_edge;
    logic [BUS_WIDTH:0]       w_sum;
    logic                     w_clip;
    logic [BUS_WIDTH-1:0]     w_acc_next;

    assign w_edge     = r_s & ~r_s_d;
    assign w_sum      = {1'b0, r_acc} + c_Q_STEP;
    assign w_clip     = (w_sum > c_ACC_MAX);
    assign w_acc_next = w_clip ? c_ACC_MAX[BUS_WIDTH-1:0] : w_sum[BUS_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_sync1     <= 1'b0;
            r_s         <= 1'b0;
            r_s_d       <= 1'b0;
            r_acc       <= '0;
            r_low       <= '0;
            r_sat       <= 1'b0;
            r_q         <= '0;
            r_ready     <= 1'b0;
            r_saturated <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sync1 <= q_serialized;
            r_s     <= r_sync1;
            r_s_d   <= r_s;
            r_ready <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    r_acc <= '0;
                    r_low <= '0;
                    r_sat <= 1'b0;
                    if (enable && w_edge) begin
                        r_acc   <= c_Q_STEP[BUS_WIDTH-1:0];
                        r_state <= c_S_COUNT;
                        r_busy  <= 1'b1;
                    end
                end
                c_S_COUNT: begin
                    if (!enable) begin
                        // Abandon the burst silently; published result is kept.
                        r_state <= c_S_IDLE;
                        r_busy  <= 1'b0;
                        r_acc   <= '0;
                        r_low   <= '0;
                        r_sat   <= 1'b0;
                    end else begin
                        if (w_edge) begin
                            r_acc <= w_acc_next;
                            if (w_clip) r_sat <= 1'b1;
                        end
                        if (r_s) begin
                            r_low <= '0;
                        end else if (r_low != c_LOW_LAST) begin
                            r_low <= r_low + 1'b1;
                        end else begin
                            r_q         <= r_acc;
                            r_saturated <= r_sat;
                            r_ready     <= 1'b1;
                            r_acc       <= '0;
                            r_low       <= '0;
                            r_sat       <= 1'b0;
                            r_state     <= c_S_IDLE;
                            r_busy      <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign q_measured = r_q;
    assign ready      = r_ready;
    assign saturated  = r_saturated;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_q_pulse_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_q_pulse_meter                                                 |
// | Brief   : Scoreboard bench for q_pulse_meter with a pulse-level model.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_q_pulse_meter;

    localparam int c_BW   = 10;
    localparam int c_Q    = 3;
    localparam int c_MAX  = (1 << c_BW) - 1;

    typedef struct {
        int q;
        bit sat;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b0;
    logic            q_serialized = 1'b0;
    logic [c_BW-1:0] q_measured;
    logic            ready;
    logic            saturated;
    logic            busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    q_pulse_meter #(.BUS_WIDTH(c_BW), .Q_PER_PULSE(c_Q), .WTD_BUS_WIDTH(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .q_serialized(q_serialized),
        .q_measured  (q_measured),
        .ready       (ready),
        .saturated   (saturated),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // A burst of n pulses is worth n*Q, clipped at full scale.
    task automatic expect_burst(input int n);
        exp_t e;
        e.sat = (n * c_Q) > c_MAX;
        e.q   = e.sat ? c_MAX : n * c_Q;
        exp_q.push_back(e);
    endtask

    task automatic burst(input int n, input int hi, input int gap, input int tail);
        for (int i = 0; i < n; i++) begin
            q_serialized = 1'b1;
            repeat (hi) @(negedge clk);
            q_serialized = 1'b0;
            repeat ((i == n - 1) ? tail : gap) @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("q_measured", int'(q_measured), e.q);
                check("saturated", int'(saturated), int'(e.sat));
            end
        end
    end

    initial begin
        int cnt;
        int busy_seen;
        int q_before;

        repeat (3) @(negedge clk);
        check("rst_q_measured", int'(q_measured), 0);
        check("rst_ready", int'(ready), 0);
        check("rst_saturated", int'(saturated), 0);
        check("rst_busy", int'(busy), 0);
        rst    = 1'b0;
        enable = 1'b1;
        repeat (4) @(negedge clk);

        // Five pulses, then measure end-of-burst latency from the last fall
        expect_burst(5);
        burst(4, 3, 3, 3);
        q_serialized = 1'b1;
        repeat (3) @(negedge clk);
        q_serialized = 1'b0;
        cnt = 0;
        while (cnt < 30) begin
            @(posedge clk);
            #1;
            cnt++;
            if (ready === 1'b1) break;
        end
        check("ready_latency", cnt, 9);
        @(negedge clk);
        check("busy_after_ready", int'(busy), 0);
        repeat (5) @(negedge clk);

        // Saturation, then a small burst clears the flag
        expect_burst(342);
        burst(342, 3, 3, 12);
        expect_burst(2);
        burst(2, 3, 3, 12);

        // Gap tolerance: 6 low cycles join, 12 split
        expect_burst(2);
        burst(2, 3, 6, 12);
        expect_burst(1);
        burst(1, 3, 0, 12);
        expect_burst(1);
        burst(1, 3, 0, 12);

        // Disabled: pulses ignored, result held
        q_before  = int'(q_measured);
        enable    = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            q_serialized = 1'b1;
            repeat (3) begin @(negedge clk); if (busy) busy_seen = 1; end
            q_serialized = 1'b0;
            repeat (3) begin @(negedge clk); if (busy) busy_seen = 1; end
        end
        repeat (12) begin @(negedge clk); if (busy) busy_seen = 1; end
        check("disabled_busy", busy_seen, 0);
        check("disabled_q_held", int'(q_measured), q_before);
        enable = 1'b1;
        @(negedge clk);

        // Enable dropped mid-burst
        burst(2, 3, 3, 3);
        check("busy_mid_burst", int'(busy), 1);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("busy_after_disable", int'(busy), 0);
        repeat (12) @(negedge clk);
        check("abandon_q_held", int'(q_measured), q_before);
        enable = 1'b1;
        @(negedge clk);

        // Reset mid-burst after a 12-unit result
        expect_burst(4);
        burst(4, 3, 3, 12);
        burst(3, 3, 3, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_q", int'(q_measured), 0);
        check("rst_mid_ready", int'(ready), 0);
        check("rst_mid_sat", int'(saturated), 0);
        check("rst_mid_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        expect_burst(2);
        burst(2, 3, 3, 12);

        // Back-to-back: next burst starts right after the strobe
        expect_burst(2);
        burst(2, 3, 3, 0);
        cnt = 0;
        while (cnt < 30 && ready !== 1'b1) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("b2b_ready_seen", int'(ready === 1'b1), 1);
        expect_burst(3);
        @(negedge clk);
        burst(3, 3, 3, 12);

        // Randomized bursts
        for (int k = 0; k < 10; k++) begin
            int n;
            n = int'($urandom_range(1, 25));
            expect_burst(n);
            burst(n, int'($urandom_range(2, 4)), int'($urandom_range(1, 6)),
                  int'($urandom_range(7, 15)));
        end

        repeat (30) @(negedge clk);
        check("pending_expected", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/q_pulse_meter.md
# q_pulse_meter

Converts the serialized charge pulse train (`q_serialized`) from the resonant system into a parallel measured-Q word for the Q control loop. Every synchronized rising edge of the pulse train adds `Q_PER_PULSE` to an accumulator. A watchdog on the input's low time decides when a burst has ended. At that point the block publishes `q_measured` together with a one-cycle `ready` strobe. It sits between the resonant system and `q_control` inside `top`.

## Interface
- `BUS_WIDTH`, 10: width of `q_measured` and the accumulator.
- `Q_PER_PULSE`, 3: charge units added per detected pulse; must be ≥1 and < 2^BUS_WIDTH.
- `WTD_BUS_WIDTH`, 3: watchdog counter width; a burst ends after WTD_MAX = 2^WTD_BUS_WIDTH−1 consecutive low samples.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: measurement enable; when low, the block is forced to IDLE and pulses are ignored.
- `q_serialized` in 1: pulse train, asynchronous to `clk`; each pulse is high for ≥2 `clk` cycles.
- `q_measured` out BUS_WIDTH: last completed burst total, saturating; holds until the next burst completes.
- `ready` out 1: one-cycle strobe; `q_measured` is valid in the same cycle and after it.
- `saturated` out 1: set with `ready` when that burst's total clipped at 2^BUS_WIDTH−1; cleared with the next `ready`.
- `busy` out 1: high in COUNT state.

## Operation
- Input path:
  - Two-flop synchronizer gives `s`; a registered copy `s_d` is kept alongside it.
  - `edge = s & ~s_d`.
  - Synchronizer flops reset to 0.
- States: IDLE, COUNT.
- IDLE:
  - acc = 0, lowcnt = 0.
  - On `edge` with `enable`=1: acc ← Q_PER_PULSE, go to COUNT.
- COUNT:
  - On `edge`: acc ← min(acc + Q_PER_PULSE, 2^BUS_WIDTH−1); the sat flag is set if clipping occurs.
  - Sum computed at BUS_WIDTH+1 bits before the clip.
  - If `s`=1: lowcnt ← 0.
  - If `s`=0 and lowcnt < WTD_MAX−1: lowcnt ← lowcnt+1.
  - If `s`=0 and lowcnt = WTD_MAX−1 (the WTD_MAX-th consecutive low sample):
    - q_measured ← acc, saturated ← sat flag, ready ← 1;
    - acc, lowcnt and the sat flag are cleared; go to IDLE.
- `enable` falling in COUNT:
  - Go to IDLE next cycle; acc is discarded.
  - No `ready`; `q_measured` and `saturated` keep their old values.
- `rst`: next edge sets state IDLE and clears acc, lowcnt, sat flag, synchronizer, `q_measured`=0, `ready`=0, `saturated`=0, `busy`=0. `rst` has priority over every other event.
- An edge on the same cycle as the completing low sample is impossible, because an edge implies `s`=1.
- An edge arriving on the cycle after `ready` starts a new burst from IDLE normally.

## Timing
- Reset values: `q_measured`=0, `ready`=0, `saturated`=0, `busy`=0.
- Pulse detection latency:
  - `q_serialized` rising → `edge` 2 cycles later (synchronizer).
  - acc updated at the following clock edge.
- End-of-burst latency:
  - `ready` is high for the cycle starting at the clock edge that samples the WTD_MAX-th consecutive `s`=0.
  - Measured from the falling edge of the last pulse, this is WTD_MAX+2 cycles (9 cycles for WTD_BUS_WIDTH=3).
- `ready` is exactly 1 cycle wide. `q_measured` changes only on the same edge that raises `ready`.
- `busy` rises 1 cycle after the first `edge`. It falls on the same edge that raises `ready`.
- Low gaps ≤ WTD_MAX−1 synchronized cycles do not end a burst.
- Throughput: a new burst may begin 1 cycle after `ready`.
- `q_control` may sample `q_measured` on any cycle where `ready`=1.

## Test plan
- Defaults, `enable`=1, 5 pulses (3 high, 3 low) → `ready` once, `q_measured`=15, `saturated`=0. `ready` occurs 9 cycles after the last falling edge.
- 342 pulses with 3-cycle gaps → `q_measured`=1023, `saturated`=1. A following 2-pulse burst → `q_measured`=6, `saturated`=0.
- Gap tolerance: two pulses separated by 6 low cycles → a single burst, `q_measured`=6. The same pulses separated by 12 low cycles → two `ready` strobes, each with `q_measured`=3.
- `enable`=0 while 4 pulses arrive → no `ready`, `busy`=0, `q_measured` unchanged. `enable` dropped mid-burst after 2 pulses → no `ready`; `busy` falls the next cycle.
- `rst` pulsed for 1 cycle mid-burst after 3 pulses (previous `q_measured`=12) → all outputs 0 on the next cycle. A subsequent 2-pulse burst → `q_measured`=6.
- Back-to-back: a new pulse starting 1 cycle after `ready` → counted fully in the next burst; no pulse lost.
